// File: rtl/usb_pkg.sv
// Shared definitions for the USB standard-request decoder.
//   - bRequest codes, descriptor type codes and fixed descriptor lengths
//   - SETUP packet layout (bytes in arrival order, byte 0 in the LSBs)
//   - decoder FSM state encoding
//   - clamp_len: shorten a descriptor length to the host's wLength
package usb_pkg;

    localparam int unsigned SETUP_BYTES = 8;
    localparam int unsigned SETUP_CNT_W = $clog2(SETUP_BYTES);

    localparam logic [7:0] REQ_SET_ADDRESS       = 8'h05;
    localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'h06;
    localparam logic [7:0] REQ_GET_CONFIGURATION = 8'h08;
    localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;

    localparam logic [7:0] DESC_DEVICE = 8'h01;
    localparam logic [7:0] DESC_CONFIG = 8'h02;
    localparam logic [7:0] DESC_STRING = 8'h03;

    localparam int unsigned DEV_DESC_LEN = 18;
    localparam int unsigned STR0_LEN     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DECODE,
        ST_DRAIN
    } state_t;

    // Multi-byte fields are little-endian on the wire, so a flat byte
    // vector with byte 0 in the LSBs maps directly onto this layout.
    typedef struct packed {
        logic [15:0] w_length;
        logic [15:0] w_index;
        logic [15:0] w_value;
        logic [7:0]  b_request;
        logic [7:0]  bm_request_type;
    } setup_pkt_t;

    // Full 16-bit compare: any wLength >= 256 selects the descriptor length.
    function automatic logic [7:0] clamp_len(input logic [15:0] w_length,
                                             input logic [7:0]  len);
        return (w_length < {8'h00, len}) ? w_length[7:0] : len;
    endfunction

endpackage

// File: rtl/usb_desc_lut.sv
// Descriptor lookup: maps (descriptor type, index) to a ROM window.
// Ports:
//   dtype  in  8       descriptor type (wValue high byte)
//   idx    in  8       descriptor index (wValue low byte)
//   hit    out 1       descriptor exists
//   base   out ROM_AW  ROM start address of the descriptor
//   len    out 8       full descriptor length in bytes
// Purely combinational; outputs are zero when hit is low.
module usb_desc_lut
    import usb_pkg::*;
#(
    parameter int unsigned ROM_AW     = 9,
    parameter int unsigned NUM_STR    = 4,
    parameter int unsigned DEV_BASE   = 0,
    parameter int unsigned CFG_BASE   = 24,
    parameter int unsigned CFG_LEN    = 59,
    parameter int unsigned STR_BASE   = 88,
    parameter int unsigned STR_STRIDE = 64,
    parameter int unsigned STR_LEN    = 52
) (
    input  logic [7:0]        dtype,
    input  logic [7:0]        idx,
    output logic              hit,
    output logic [ROM_AW-1:0] base,
    output logic [7:0]        len
);

    // Type/index decode into ROM window
    always_comb begin
        hit  = 1'b0;
        base = '0;
        len  = '0;
        case (dtype)
            DESC_DEVICE: begin
                hit  = 1'b1;
                base = ROM_AW'(DEV_BASE);
                len  = 8'(DEV_DESC_LEN);
            end
            DESC_CONFIG: begin
                hit  = 1'b1;
                base = ROM_AW'(CFG_BASE);
                len  = 8'(CFG_LEN);
            end
            DESC_STRING: begin
                if (32'(idx) < NUM_STR) begin
                    hit  = 1'b1;
                    base = ROM_AW'(STR_BASE + 32'(idx) * STR_STRIDE);
                    // String 0 is the LANGID table, which is shorter
                    len  = (idx == 8'd0) ? 8'(STR0_LEN) : 8'(STR_LEN);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/usb_stdreq_decoder.sv
// USB control-endpoint standard-request decoder.
// Collects the 8-byte SETUP packet from the RX FIFO, decodes it and drives
// the descriptor ROM window, device address and configuration value.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   setupdataactive   SETUP data phase in progress
//   empty_rx          RX FIFO empty
//   datao_rx [7:0]    RX FIFO head byte (first-word-fall-through)
//   pop_rx            consume head byte (combinational from state/empty_rx)
//   status_done       status stage ACKed (one-cycle pulse)
//   romaddr [ROM_AW]  descriptor start address
//   romnum [7:0]      bytes to send
//   devaddress [6:0]  active device address
//   cfg_value [7:0]   current configuration value
//   req_valid         one-cycle pulse: request accepted, outputs updated
//   req_stall         one-cycle pulse: request unsupported
// Build option: USB_STDREQ_CONFIG_EN enables SET/GET_CONFIGURATION;
// without it both stall and cfg_value stays 0.
module usb_stdreq_decoder
    import usb_pkg::*;
#(
    parameter int unsigned ROM_AW     = 9,
    parameter int unsigned NUM_STR    = 4,
    parameter int unsigned DEV_BASE   = 0,
    parameter int unsigned CFG_BASE   = 24,
    parameter int unsigned CFG_LEN    = 59,
    parameter int unsigned STR_BASE   = 88,
    parameter int unsigned STR_STRIDE = 64,
    parameter int unsigned STR_LEN    = 52
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              setupdataactive,
    input  logic              empty_rx,
    input  logic [7:0]        datao_rx,
    output logic              pop_rx,
    input  logic              status_done,
    output logic [ROM_AW-1:0] romaddr,
    output logic [7:0]        romnum,
    output logic [6:0]        devaddress,
    output logic [7:0]        cfg_value,
    output logic              req_valid,
    output logic              req_stall
);

    localparam int unsigned SETUP_W = 8 * SETUP_BYTES;

    state_t                 state_q, state_nxt;
    logic [SETUP_CNT_W-1:0] cnt_q, cnt_nxt;
    logic [SETUP_W-1:0]     setup_q, setup_nxt;
    logic [ROM_AW-1:0]      romaddr_q, romaddr_nxt;
    logic [7:0]             romnum_q, romnum_nxt;
    logic [6:0]             devaddr_q, devaddr_nxt;
    logic [7:0]             cfg_q, cfg_nxt;
    logic                   valid_q, valid_nxt;
    logic                   stall_q, stall_nxt;
    logic [6:0]             pend_addr_q, pend_addr_nxt;
    logic                   pend_vld_q, pend_vld_nxt;

    setup_pkt_t        pkt;
    logic              lut_hit;
    logic [ROM_AW-1:0] lut_base;
    logic [7:0]        lut_len;
    logic              unused_bits;

    assign pkt = setup_pkt_t'(setup_q);

    // Recipient, direction and wIndex play no part in these requests
    assign unused_bits = ^{pkt.bm_request_type[7], pkt.bm_request_type[4:0],
                           pkt.w_index};

    // FIFO handshake
    assign pop_rx = ((state_q == ST_COLLECT) || (state_q == ST_DRAIN)) && !empty_rx;

    // Descriptor window lookup
    usb_desc_lut #(
        .ROM_AW     (ROM_AW),
        .NUM_STR    (NUM_STR),
        .DEV_BASE   (DEV_BASE),
        .CFG_BASE   (CFG_BASE),
        .CFG_LEN    (CFG_LEN),
        .STR_BASE   (STR_BASE),
        .STR_STRIDE (STR_STRIDE),
        .STR_LEN    (STR_LEN)
    ) u_desc_lut (
        .dtype (pkt.w_value[15:8]),
        .idx   (pkt.w_value[7:0]),
        .hit   (lut_hit),
        .base  (lut_base),
        .len   (lut_len)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        setup_nxt     = setup_q;
        romaddr_nxt   = romaddr_q;
        romnum_nxt    = romnum_q;
        devaddr_nxt   = devaddr_q;
        cfg_nxt       = cfg_q;
        valid_nxt     = 1'b0;
        stall_nxt     = 1'b0;
        pend_addr_nxt = pend_addr_q;
        pend_vld_nxt  = pend_vld_q;

        // A SET_ADDRESS takes effect only once its status stage completes
        if (status_done && pend_vld_q) begin
            devaddr_nxt  = pend_addr_q;
            pend_vld_nxt = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (setupdataactive) begin
                    cnt_nxt      = '0;
                    // Stale window must not be sent while a new request is in flight
                    romnum_nxt   = '0;
                    // A new SETUP aborts any SET_ADDRESS still awaiting status
                    pend_vld_nxt = 1'b0;
                    state_nxt    = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (pop_rx) begin
                    setup_nxt[{cnt_q, 3'b000} +: 8] = datao_rx;
                    cnt_nxt = cnt_q + SETUP_CNT_W'(1);
                    if (cnt_q == SETUP_CNT_W'(SETUP_BYTES - 1)) begin
                        state_nxt = ST_DECODE;
                    end
                end else if (!setupdataactive) begin
                    // Truncated packet: drop silently
                    state_nxt = ST_IDLE;
                end
            end

            ST_DECODE: begin
                state_nxt = ST_DRAIN;
                stall_nxt = 1'b1;
                // Only standard requests (type field 00) are handled
                if (pkt.bm_request_type[6:5] == 2'b00) begin
                    case (pkt.b_request)
                        REQ_GET_DESCRIPTOR: begin
                            if (lut_hit) begin
                                romaddr_nxt = lut_base;
                                romnum_nxt  = clamp_len(pkt.w_length, lut_len);
                                valid_nxt   = 1'b1;
                                stall_nxt   = 1'b0;
                            end
                        end
                        REQ_SET_ADDRESS: begin
                            pend_addr_nxt = pkt.w_value[6:0];
                            pend_vld_nxt  = 1'b1;
                            romnum_nxt    = '0;
                            valid_nxt     = 1'b1;
                            stall_nxt     = 1'b0;
                        end
`ifdef USB_STDREQ_CONFIG_EN
                        REQ_SET_CONFIGURATION: begin
                            if (pkt.w_value[7:1] == 7'd0) begin
                                cfg_nxt    = pkt.w_value[7:0];
                                romnum_nxt = '0;
                                valid_nxt  = 1'b1;
                                stall_nxt  = 1'b0;
                            end
                        end
                        REQ_GET_CONFIGURATION: begin
                            // IN path sends cfg_value; ROM window is left alone
                            romnum_nxt = clamp_len(pkt.w_length, 8'd1);
                            valid_nxt  = 1'b1;
                            stall_nxt  = 1'b0;
                        end
`else
                        REQ_SET_CONFIGURATION, REQ_GET_CONFIGURATION: ;
`endif
                        default: ;
                    endcase
                end
            end

            ST_DRAIN: begin
                // Excess bytes are popped by pop_rx until the phase ends
                if (empty_rx && !setupdataactive) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            setup_q     <= '0;
            romaddr_q   <= '0;
            romnum_q    <= '0;
            devaddr_q   <= '0;
            cfg_q       <= '0;
            valid_q     <= 1'b0;
            stall_q     <= 1'b0;
            pend_addr_q <= '0;
            pend_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            setup_q     <= setup_nxt;
            romaddr_q   <= romaddr_nxt;
            romnum_q    <= romnum_nxt;
            devaddr_q   <= devaddr_nxt;
            cfg_q       <= cfg_nxt;
            valid_q     <= valid_nxt;
            stall_q     <= stall_nxt;
            pend_addr_q <= pend_addr_nxt;
            pend_vld_q  <= pend_vld_nxt;
        end
    end

    assign romaddr    = romaddr_q;
    assign romnum     = romnum_q;
    assign devaddress = devaddr_q;
    assign cfg_value  = cfg_q;
    assign req_valid  = valid_q;
    assign req_stall  = stall_q;

endmodule

// File: tb/tb_usb_stdreq_decoder.sv
// Bench for usb_stdreq_decoder: directed SETUP packets followed by random
// ones, checked against a transaction-level model of the request rules.
module tb_usb_stdreq_decoder;

    localparam int unsigned ROM_AW     = 9;
    localparam int unsigned NUM_STR    = 4;
    localparam int unsigned DEV_BASE   = 0;
    localparam int unsigned CFG_BASE   = 24;
    localparam int unsigned CFG_LEN    = 59;
    localparam int unsigned STR_BASE   = 88;
    localparam int unsigned STR_STRIDE = 64;
    localparam int unsigned STR_LEN    = 52;

    logic              clk = 1'b0;
    logic              rst;
    logic              setupdataactive;
    logic              empty_rx;
    logic [7:0]        datao_rx;
    logic              pop_rx;
    logic              status_done;
    logic [ROM_AW-1:0] romaddr;
    logic [7:0]        romnum;
    logic [6:0]        devaddress;
    logic [7:0]        cfg_value;
    logic              req_valid;
    logic              req_stall;

    always #5 clk = ~clk;

    usb_stdreq_decoder #(
        .ROM_AW     (ROM_AW),
        .NUM_STR    (NUM_STR),
        .DEV_BASE   (DEV_BASE),
        .CFG_BASE   (CFG_BASE),
        .CFG_LEN    (CFG_LEN),
        .STR_BASE   (STR_BASE),
        .STR_STRIDE (STR_STRIDE),
        .STR_LEN    (STR_LEN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .setupdataactive (setupdataactive),
        .empty_rx        (empty_rx),
        .datao_rx        (datao_rx),
        .pop_rx          (pop_rx),
        .status_done     (status_done),
        .romaddr         (romaddr),
        .romnum          (romnum),
        .devaddress      (devaddress),
        .cfg_value       (cfg_value),
        .req_valid       (req_valid),
        .req_stall       (req_stall)
    );

    logic [7:0] rxq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_valid;
    int n_stall;

    // Reference state
    logic [ROM_AW-1:0] m_romaddr;
    logic [7:0]        m_romnum;
    logic [6:0]        m_dev;
    logic [7:0]        m_cfg;
    logic              m_pend_vld;
    logic [6:0]        m_pend;
    int                exp_valid;
    int                exp_stall;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: present FIFO head, pop on handshake, count output pulses
    task automatic cycle();
        logic popped;
        empty_rx = (rxq.size() == 0);
        datao_rx = empty_rx ? 8'h00 : rxq[0];
        #1;
        popped = (pop_rx === 1'b1) && !empty_rx;
        @(posedge clk);
        if (popped) void'(rxq.pop_front());
        #1;
        if (req_valid === 1'b1) n_valid++;
        if (req_stall === 1'b1) n_stall++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_romaddr  = '0;
        m_romnum   = '0;
        m_dev      = '0;
        m_cfg      = '0;
        m_pend_vld = 1'b0;
        m_pend     = '0;
    endtask

    function automatic logic [7:0] clamp(input logic [15:0] wl, input int len);
        return (int'(wl) < len) ? wl[7:0] : 8'(len);
    endfunction

    // Applies one complete SETUP packet to the reference state
    task automatic model_request(input logic [7:0] p[8]);
        logic [15:0] wv;
        logic [15:0] wl;
        int          t;
        int          i;
        bit          ok;
        wv = {p[3], p[2]};
        wl = {p[7], p[6]};
        t  = int'(wv[15:8]);
        i  = int'(wv[7:0]);
        ok = 1'b0;
        if (p[0][6:5] == 2'b00) begin
            case (p[1])
                8'h06: begin
                    if (t == 1) begin
                        ok = 1'b1; m_romaddr = ROM_AW'(DEV_BASE); m_romnum = clamp(wl, 18);
                    end else if (t == 2) begin
                        ok = 1'b1; m_romaddr = ROM_AW'(CFG_BASE); m_romnum = clamp(wl, CFG_LEN);
                    end else if (t == 3 && i < NUM_STR) begin
                        ok = 1'b1;
                        m_romaddr = ROM_AW'(STR_BASE + i * STR_STRIDE);
                        m_romnum  = clamp(wl, (i == 0) ? 4 : STR_LEN);
                    end
                end
                8'h05: begin
                    ok = 1'b1; m_pend_vld = 1'b1; m_pend = wv[6:0]; m_romnum = 8'h00;
                end
`ifdef USB_STDREQ_CONFIG_EN
                8'h09: begin
                    if (i <= 1) begin
                        ok = 1'b1; m_cfg = wv[7:0]; m_romnum = 8'h00;
                    end
                end
                8'h08: begin
                    ok = 1'b1; m_romnum = clamp(wl, 1);
                end
`endif
                default: ;
            endcase
        end
        exp_valid = ok ? 1 : 0;
        exp_stall = ok ? 0 : 1;
    endtask

    // Sends a packet of any length with random byte gaps, then checks the outcome
    task automatic run_setup(input logic [7:0] pkt[$], input string tag);
        logic [7:0] p[8];
        int k;
        m_pend_vld = 1'b0;
        m_romnum   = 8'h00;
        exp_valid  = 0;
        exp_stall  = 0;
        n_valid    = 0;
        n_stall    = 0;
        setupdataactive = 1'b1;
        k = 0;
        for (int guard = 0; guard < 400 && (k < pkt.size() || rxq.size() != 0); guard++) begin
            if (k < pkt.size() && $urandom_range(0, 2) != 0) begin
                rxq.push_back(pkt[k]);
                k++;
            end
            cycle();
        end
        setupdataactive = 1'b0;
        for (int c = 0; c < 6; c++) cycle();
        check_eq({tag, "/consumed"}, 32'(rxq.size()), 32'd0);
        rxq.delete();
        if (pkt.size() >= 8) begin
            for (int b = 0; b < 8; b++) p[b] = pkt[b];
            model_request(p);
        end
        check_eq({tag, "/valid"},   32'(n_valid),   32'(exp_valid));
        check_eq({tag, "/stall"},   32'(n_stall),   32'(exp_stall));
        check_eq({tag, "/romaddr"}, 32'(romaddr),   32'(m_romaddr));
        check_eq({tag, "/romnum"},  32'(romnum),    32'(m_romnum));
        check_eq({tag, "/devaddr"}, 32'(devaddress), 32'(m_dev));
        check_eq({tag, "/cfg"},     32'(cfg_value), 32'(m_cfg));
    endtask

    // Packet written MSB-first as it appears on the wire; n may exceed 8
    task automatic run_hex(input logic [63:0] h, input int n, input string tag);
        logic [7:0] q[$];
        for (int i = 0; i < n; i++) begin
            if (i < 8) q.push_back(h[63 - 8 * i -: 8]);
            else       q.push_back(8'($urandom));
        end
        run_setup(q, tag);
    endtask

    task automatic pulse_status(input string tag);
        status_done = 1'b1;
        cycle();
        status_done = 1'b0;
        if (m_pend_vld) begin
            m_dev      = m_pend;
            m_pend_vld = 1'b0;
        end
        check_eq({tag, "/status_dev"}, 32'(devaddress), 32'(m_dev));
        cycle();
    endtask

    task automatic run_random(input int n);
        logic [7:0] q[$];
        logic [7:0] lo;
        logic [15:0] wl;
        int len;
        q.delete();
        case ($urandom_range(0, 7))
            0, 1, 2: q.push_back(8'h80);
            3, 4:    q.push_back(8'h00);
            5:       q.push_back(8'h20);
            6:       q.push_back(8'hC0);
            default: q.push_back(8'($urandom));
        endcase
        case ($urandom_range(0, 7))
            0, 1, 2: q.push_back(8'h06);
            3:       q.push_back(8'h05);
            4:       q.push_back(8'h08);
            5:       q.push_back(8'h09);
            default: q.push_back(8'($urandom));
        endcase
        lo = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
        q.push_back(lo);
        case ($urandom_range(0, 4))
            0:       q.push_back(8'h01);
            1:       q.push_back(8'h02);
            2, 3:    q.push_back(8'h03);
            default: q.push_back(8'($urandom));
        endcase
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        case ($urandom_range(0, 5))
            0:       wl = 16'h0000;
            1:       wl = 16'($urandom_range(1, 80));
            2:       wl = 16'h0400;
            3:       wl = 16'h0100;
            4:       wl = 16'h00FF;
            default: wl = 16'($urandom);
        endcase
        q.push_back(wl[7:0]);
        q.push_back(wl[15:8]);
        case ($urandom_range(0, 7))
            0:       len = 5;
            1:       len = 10;
            default: len = 8;
        endcase
        while (q.size() > len) void'(q.pop_back());
        while (q.size() < len) q.push_back(8'($urandom));
        run_setup(q, $sformatf("rnd%0d", n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        setupdataactive = 1'b0;
        status_done = 1'b0;
        empty_rx = 1'b1;
        datao_rx = 8'h00;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        check_eq("rst/romaddr", 32'(romaddr),    32'd0);
        check_eq("rst/romnum",  32'(romnum),     32'd0);
        check_eq("rst/devaddr", 32'(devaddress), 32'd0);
        check_eq("rst/cfg",     32'(cfg_value),  32'd0);
        check_eq("rst/pop",     32'(pop_rx),     32'd0);
        check_eq("rst/valid",   32'(req_valid),  32'd0);
        check_eq("rst/stall",   32'(req_stall),  32'd0);
        rst = 1'b0;
        cycle();

        // Descriptor windows
        run_hex(64'h80_06_00_01_00_00_40_00, 8, "get_dev");
        check_eq("get_dev/romnum_18", 32'(romnum), 32'd18);
        run_hex(64'h80_06_00_02_00_00_09_00, 8, "get_cfg9");
        check_eq("get_cfg9/romaddr_24", 32'(romaddr), 32'd24);
        check_eq("get_cfg9/romnum_9",   32'(romnum),  32'd9);
        run_hex(64'h80_06_00_02_00_00_00_04, 8, "get_cfg_big");
        check_eq("get_cfg_big/romnum_59", 32'(romnum), 32'd59);
        run_hex(64'h80_06_02_03_09_04_FF_00, 8, "get_str2");
        check_eq("get_str2/romaddr_216", 32'(romaddr), 32'd216);
        check_eq("get_str2/romnum_52",   32'(romnum),  32'd52);
        run_hex(64'h80_06_00_03_09_04_FF_00, 8, "get_str0");
        run_hex(64'h80_06_04_03_09_04_FF_00, 8, "get_str4");
        run_hex(64'h80_06_00_07_00_00_40_00, 8, "get_badtype");
        run_hex(64'h80_06_00_01_00_00_00_00, 8, "get_wlen0");
        run_hex(64'hC0_06_00_01_00_00_40_00, 8, "vendor");
        run_hex(64'h80_07_00_01_00_00_40_00, 8, "unknown_req");

        // SET_ADDRESS applies only after status
        run_hex(64'h00_05_2A_00_00_00_00_00, 8, "setaddr");
        check_eq("setaddr/before_status", 32'(devaddress), 32'd0);
        pulse_status("setaddr");
        check_eq("setaddr/after_status", 32'(devaddress), 32'h2A);
        run_hex(64'h00_05_15_00_00_00_00_00, 8, "setaddr2");
        run_hex(64'h80_06_00_01_00_00_40_00, 8, "abort_setup");
        pulse_status("abort");
        check_eq("abort/devaddr_kept", 32'(devaddress), 32'h2A);

        // Framing
        run_hex(64'h80_06_00_01_00_00_40_00, 5, "trunc5");
        run_hex(64'h80_06_00_02_00_00_10_00, 10, "long10");

        // Configuration requests
        run_hex(64'h00_09_01_00_00_00_00_00, 8, "setcfg1");
        run_hex(64'h80_08_00_00_00_00_01_00, 8, "getcfg");
        run_hex(64'h00_09_03_00_00_00_00_00, 8, "setcfg3");

        // Random traffic with occasional status stages
        for (int n = 0; n < 80; n++) begin
            run_random(n);
            if ($urandom_range(0, 1) == 1) pulse_status($sformatf("rnd%0d", n));
        end

        // Reset in the middle of a packet
        run_hex(64'h00_05_33_00_00_00_00_00, 8, "pre_rst");
        pulse_status("pre_rst");
        setupdataactive = 1'b1;
        rxq.push_back(8'h80);
        rxq.push_back(8'h06);
        rxq.push_back(8'h00);
        for (int c = 0; c < 3; c++) cycle();
        rst = 1'b1;
        setupdataactive = 1'b0;
        rxq.delete();
        model_reset();
        cycle();
        cycle();
        check_eq("midrst/romaddr", 32'(romaddr),    32'd0);
        check_eq("midrst/romnum",  32'(romnum),     32'd0);
        check_eq("midrst/devaddr", 32'(devaddress), 32'd0);
        check_eq("midrst/cfg",     32'(cfg_value),  32'd0);
        rst = 1'b0;
        cycle();
        run_hex(64'h80_06_01_03_00_00_40_00, 8, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
